// File: rtl/pipe_add_sub_pkg.sv
// Shared types and helpers for the pipelined adder/subtractor.
// The stage record is sized for the widest supported operand so that one
// typedef serves every WIDTH/CHUNK combination; unused upper bits stay zero.
package pipe_add_sub_pkg;

    localparam int MAX_WIDTH = 64;

    // One skew/deskew pipeline record: control bits, unresolved operand
    // slices (shifted down so the next slice to resolve sits at bit 0) and
    // the sum slices collected so far (kept at their final bit positions).
    typedef struct packed {
        logic                 valid;
        logic                 carry;
        logic                 sub;
        logic [MAX_WIDTH-1:0] a_rem;
        logic [MAX_WIDTH-1:0] b_rem;
        logic [MAX_WIDTH-1:0] sum;
    } stage_t;

    // Number of pipeline stages, one CHUNK-bit slice resolved per stage.
    function automatic int calc_stages(input int width, input int chunk);
        return width / chunk;
    endfunction

    // Legal split: width is a whole number of chunks and fits the record.
    function automatic bit split_ok(input int width, input int chunk);
        return (chunk >= 1) && (width >= 2) && (width <= MAX_WIDTH) &&
               ((width % chunk) == 0);
    endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational CHUNK-bit ripple adder for one pipeline stage. Besides the
// carry-out it exposes the carry into the slice MSB, which the last stage
// needs for signed-overflow detection.
module adder_chunk #(
    parameter int CHUNK = 3
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb_in
);

    logic [CHUNK:0] c;

    // Ripple the carry bit by bit through the slice.
    always_comb begin
        // NOTE: blocking assignments here so each bit sees the carry just
        // computed for the bit below it within the same evaluation.
        c[0] = cin;
        sum  = '0;
        for (int i = 0; i < CHUNK; i++) begin
            sum[i]  = a[i] ^ b[i] ^ c[i];
            c[i+1]  = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
        end
        cout     = c[CHUNK];
        c_msb_in = c[CHUNK-1];
    end

endmodule

// File: rtl/pipe_add_sub.sv
// Pipelined two's-complement adder/subtractor. Stage k resolves slice k of
// A + B' + carry; upper slices wait in skew registers and resolved lower sum
// slices ride along in deskew registers so the full result exits together.
// Subtraction is A + ~B + ~cin, so one carry chain serves both modes.
module pipe_add_sub
    import pipe_add_sub_pkg::*;
#(
    parameter int WIDTH = 12,
    parameter int CHUNK = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int STAGES = calc_stages(WIDTH, CHUNK);
    localparam int LAST   = STAGES - 1;

    if (!split_ok(WIDTH, CHUNK)) begin : g_bad_split
        $error("pipe_add_sub: WIDTH must be a multiple of CHUNK, WIDTH >= 2");
    end

    logic              stage_en;
    stage_t            stage_in  [STAGES];
    stage_t            stage_out [STAGES];
    logic [STAGES-1:0] c_msb;

    logic             out_valid_d, out_valid_q;
    logic [WIDTH-1:0] out_sum_d,   out_sum_q;
    logic             out_cout_d,  out_cout_q;
    logic             out_ovf_d,   out_ovf_q;

    // Whole pipeline advances unless a held result is waiting on the consumer.
    always_comb begin
        stage_en = ~(out_valid_q & ~out_ready);
    end

    assign in_ready = stage_en;

    // Stage 0 sees the raw operation: B inverted and carry-in flipped for sub.
    assign stage_in[0] = '{
        valid: in_valid,
        carry: in_cin ^ in_sub,
        sub:   in_sub,
        a_rem: MAX_WIDTH'(in_a),
        b_rem: MAX_WIDTH'(in_sub ? ~in_b : in_b),
        sum:   '0
    };

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [CHUNK-1:0] slice_sum;
        logic             slice_cout;

        adder_chunk #(.CHUNK(CHUNK)) u_chunk (
            .a        (stage_in[k].a_rem[CHUNK-1:0]),
            .b        (stage_in[k].b_rem[CHUNK-1:0]),
            .cin      (stage_in[k].carry),
            .sum      (slice_sum),
            .cout     (slice_cout),
            .c_msb_in (c_msb[k])
        );

        assign stage_out[k] = '{
            valid: stage_in[k].valid,
            carry: slice_cout,
            sub:   stage_in[k].sub,
            a_rem: stage_in[k].a_rem >> CHUNK,
            b_rem: stage_in[k].b_rem >> CHUNK,
            sum:   stage_in[k].sum | (MAX_WIDTH'(slice_sum) << (k * CHUNK))
        };

        if (k > 0) begin : g_reg
            stage_t stage_d, stage_q;

            // Load the previous stage's record on advance, otherwise hold it.
            always_comb begin
                stage_d = stage_en ? stage_out[k-1] : stage_q;
            end

            // Skew/deskew record register between stage k-1 and stage k.
            always_ff @(posedge clk or negedge rst_n) begin
                // NOTE: non-blocking so every flop samples pre-edge values
                // regardless of the order the simulator runs these blocks.
                if (!rst_n) stage_q <= '0;
                else        stage_q <= stage_d;
            end

            assign stage_in[k] = stage_q;
        end
    end

    // Final stage: assemble the result, map carry to borrow, flag overflow.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_cout_d  = out_cout_q;
        out_ovf_d   = out_ovf_q;
        if (stage_en) begin
            out_valid_d = stage_out[LAST].valid;
            out_sum_d   = stage_out[LAST].sum[WIDTH-1:0];
            out_cout_d  = stage_out[LAST].carry ^ stage_out[LAST].sub;
            out_ovf_d   = c_msb[LAST] ^ stage_out[LAST].carry;
        end
    end

    // Output register; reset clears any result in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_cout_q  <= 1'b0;
            out_ovf_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_cout_q  <= out_cout_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_cout  = out_cout_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_pipe_add_sub.sv
// Self-checking bench for pipe_add_sub: scoreboarded 12/3 instance plus
// 8/8 and 16/2 instances for the parameter sweep.
module tb_pipe_add_sub;

    localparam int STAGES = 4;   // 12 / 3

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        int          acc_cycle;
        bit          chk_lat;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // 12/3 instance
    logic        in_valid, in_ready, in_cin, in_sub;
    logic [11:0] in_a, in_b;
    logic        out_valid, out_ready, out_cout, out_ovf;
    logic [11:0] out_sum;

    // 8/8 instance
    logic        s8_in_valid, s8_in_ready, s8_in_cin, s8_in_sub;
    logic [7:0]  s8_in_a, s8_in_b;
    logic        s8_out_valid, s8_out_ready, s8_out_cout, s8_out_ovf;
    logic [7:0]  s8_out_sum;

    // 16/2 instance
    logic        s16_in_valid, s16_in_ready, s16_in_cin, s16_in_sub;
    logic [15:0] s16_in_a, s16_in_b;
    logic        s16_out_valid, s16_out_ready, s16_out_cout, s16_out_ovf;
    logic [15:0] s16_out_sum;

    pipe_add_sub #(.WIDTH(12), .CHUNK(3)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf)
    );

    pipe_add_sub #(.WIDTH(8), .CHUNK(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s8_in_valid), .in_ready(s8_in_ready),
        .in_a(s8_in_a), .in_b(s8_in_b), .in_cin(s8_in_cin), .in_sub(s8_in_sub),
        .out_valid(s8_out_valid), .out_ready(s8_out_ready),
        .out_sum(s8_out_sum), .out_cout(s8_out_cout), .out_ovf(s8_out_ovf)
    );

    pipe_add_sub #(.WIDTH(16), .CHUNK(2)) u_dut16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s16_in_valid), .in_ready(s16_in_ready),
        .in_a(s16_in_a), .in_b(s16_in_b), .in_cin(s16_in_cin), .in_sub(s16_in_sub),
        .out_valid(s16_out_valid), .out_ready(s16_out_ready),
        .out_sum(s16_out_sum), .out_cout(s16_out_cout), .out_ovf(s16_out_ovf)
    );

    int   checks   = 0;
    int   failures = 0;
    int   cycle    = 0;
    exp_t sb[$];
    exp_t pending;
    bit   lat_mode;
    bit   acc_flag;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Arithmetic reference on integers: unsigned carry/borrow, signed range.
    function automatic exp_t model(input int w, input longint a, input longint b,
                                   input bit cin, input bit sub);
        exp_t   e;
        longint m  = longint'(1) << w;
        longint sa = (a >= m / 2) ? a - m : a;
        longint sb_ = (b >= m / 2) ? b - m : b;
        longint r, sr;
        if (!sub) begin
            r      = a + b + longint'(cin);
            sr     = sa + sb_ + longint'(cin);
            e.cout = (r >= m);
        end else begin
            r      = a - b - longint'(cin);
            sr     = sa - sb_ - longint'(cin);
            e.cout = (r < 0);
        end
        e.sum       = 16'(r & (m - 1));
        e.ovf       = (sr >= m / 2) || (sr < -(m / 2));
        e.acc_cycle = 0;
        e.chk_lat   = 1'b0;
        return e;
    endfunction

    // One clock of the 12/3 instance: handshake bookkeeping at the negedge.
    task automatic step();
        exp_t e;
        @(negedge clk);
        acc_flag = 1'b0;
        check("in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_result", 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                check("sum",  32'(out_sum),  32'(e.sum));
                check("cout", 32'(out_cout), 32'(e.cout));
                check("ovf",  32'(out_ovf),  32'(e.ovf));
                if (e.chk_lat) check("latency", 32'(cycle - e.acc_cycle), 32'(STAGES));
            end
        end
        if (in_valid && in_ready) begin
            e           = pending;
            e.acc_cycle = cycle;
            e.chk_lat   = lat_mode;
            sb.push_back(e);
            acc_flag = 1'b1;
        end
        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic drain(input bit rand_ready);
        int budget = 100;
        while (sb.size() > 0 && budget > 0) begin
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
            step();
            budget--;
        end
        out_ready = 1'b1;
        check("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    // Directed single operation with explicitly stated expected result.
    task automatic do_op(input logic [11:0] a, input logic [11:0] b, input bit cin,
                         input bit sub, input logic [11:0] esum, input bit ecout,
                         input bit eovf);
        int budget = 10;
        in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
        pending.sum = 16'(esum); pending.cout = ecout; pending.ovf = eovf;
        acc_flag = 1'b0;
        while (!acc_flag && budget > 0) begin
            step();
            budget--;
        end
        in_valid = 1'b0;
        check("accepted", 32'(acc_flag), 32'd1);
        drain(1'b0);
    endtask

    task automatic rand_op();
        in_a   = 12'($urandom);
        in_b   = 12'($urandom);
        in_cin = 1'($urandom_range(0, 1));
        in_sub = 1'($urandom_range(0, 1));
        pending = model(12, longint'(in_a), longint'(in_b), in_cin, in_sub);
    endtask

    // One operation on a sweep instance, out_ready held high.
    task automatic sweep_op(input int w, input longint a, input longint b,
                            input bit cin, input bit sub);
        exp_t e = model(w, a, b, cin, sub);
        int   lat_exp = (w == 8) ? 1 : 8;
        int   lat = 0;
        logic ov;
        if (w == 8) begin
            s8_in_a = 8'(a); s8_in_b = 8'(b); s8_in_cin = cin; s8_in_sub = sub;
            s8_in_valid = 1'b1;
        end else begin
            s16_in_a = 16'(a); s16_in_b = 16'(b); s16_in_cin = cin; s16_in_sub = sub;
            s16_in_valid = 1'b1;
        end
        check("sweep_in_ready", 32'((w == 8) ? s8_in_ready : s16_in_ready), 32'd1);
        @(posedge clk); #1;
        s8_in_valid = 1'b0; s16_in_valid = 1'b0;
        lat = 1;
        ov = (w == 8) ? s8_out_valid : s16_out_valid;
        while (!ov && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            ov = (w == 8) ? s8_out_valid : s16_out_valid;
        end
        check("sweep_valid",   32'(ov),  32'd1);
        check("sweep_latency", 32'(lat), 32'(lat_exp));
        if (w == 8) begin
            check("sweep8_sum",  32'(s8_out_sum),  32'(e.sum));
            check("sweep8_cout", 32'(s8_out_cout), 32'(e.cout));
            check("sweep8_ovf",  32'(s8_out_ovf),  32'(e.ovf));
        end else begin
            check("sweep16_sum",  32'(s16_out_sum),  32'(e.sum));
            check("sweep16_cout", 32'(s16_out_cout), 32'(e.cout));
            check("sweep16_ovf",  32'(s16_out_ovf),  32'(e.ovf));
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int n;
        int budget;
        bit need_new;
        longint ones;

        rst_n = 1'b0;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0;
        out_ready = 1'b1;
        s8_in_valid = 1'b0; s8_in_a = '0; s8_in_b = '0; s8_in_cin = 1'b0;
        s8_in_sub = 1'b0; s8_out_ready = 1'b1;
        s16_in_valid = 1'b0; s16_in_a = '0; s16_in_b = '0; s16_in_cin = 1'b0;
        s16_in_sub = 1'b0; s16_out_ready = 1'b1;
        lat_mode = 1'b1;

        // Reset state
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_sum",   32'(out_sum),   32'd0);
        check("rst_out_cout",  32'(out_cout),  32'd0);
        check("rst_out_ovf",   32'(out_ovf),   32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed corners
        do_op(12'hFFF, 12'h001, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0);
        do_op(12'h7FF, 12'h001, 1'b0, 1'b0, 12'h800, 1'b0, 1'b1);
        do_op(12'h003, 12'h004, 1'b1, 1'b0, 12'h008, 1'b0, 1'b0);
        do_op(12'h005, 12'h007, 1'b0, 1'b1, 12'hFFE, 1'b1, 1'b0);
        do_op(12'h800, 12'h001, 1'b0, 1'b1, 12'h7FF, 1'b0, 1'b1);
        do_op(12'h010, 12'h00F, 1'b1, 1'b1, 12'h000, 1'b0, 1'b0);

        // Back-to-back stream with out_ready high: latency 4 each, no gaps
        lat_mode = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            rand_op();
            step();
            check("b2b_accept", 32'(acc_flag), 32'd1);
        end
        in_valid = 1'b0;
        drain(1'b0);

        // Backpressure: 20 random operations, out_ready toggling randomly
        lat_mode = 1'b0;
        n = 0; budget = 400; need_new = 1'b1;
        in_valid = 1'b1;
        while (n < 20 && budget > 0) begin
            if (need_new) begin
                rand_op();
                need_new = 1'b0;
            end
            out_ready = 1'($urandom_range(0, 1));
            step();
            if (acc_flag) begin
                n++;
                need_new = 1'b1;
            end
            budget--;
        end
        in_valid = 1'b0;
        check("bp_sent", 32'(n), 32'd20);
        drain(1'b1);

        // Reset mid-flight
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_op();
            step();
        end
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_sum",   32'(out_sum),   32'd0);
        check("midrst_out_cout",  32'(out_cout),  32'd0);
        check("midrst_out_ovf",   32'(out_ovf),   32'd0);
        check("midrst_in_ready",  32'(in_ready),  32'd1);
        sb.delete();
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) step();
        check("post_reset_quiet", 32'(out_valid), 32'd0);
        lat_mode = 1'b1;
        do_op(12'h123, 12'h456, 1'b0, 1'b0, 12'h579, 1'b0, 1'b0);

        // Parameter sweep: corners then random
        for (int wi = 0; wi < 2; wi++) begin
            int w = (wi == 0) ? 8 : 16;
            ones = (longint'(1) << w) - 1;
            sweep_op(w, 0,    0,    1'b0, 1'b0);
            sweep_op(w, ones, ones, 1'b1, 1'b0);
            sweep_op(w, ones, 0,    1'b1, 1'b0);
            sweep_op(w, 0,    ones, 1'b0, 1'b1);
            sweep_op(w, 0,    ones, 1'b1, 1'b1);
            sweep_op(w, ones, ones, 1'b1, 1'b1);
            sweep_op(w, ones, 0,    1'b0, 1'b1);
            for (int i = 0; i < 6; i++) begin
                sweep_op(w, longint'($urandom) & ones, longint'($urandom) & ones,
                         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
